// File: rtl/am_query_scheduler.sv
// Round-robin scheduler sharing one associative memory between NUM_REQ query
// sources; one query in flight, result returned to its owner, hung AM times out.
module am_query_scheduler #(
    parameter int NUM_REQ        = 2,
    parameter int HV_DIM         = 2000,
    parameter int LABEL_W        = 1,
    parameter int DIST_W         = 11,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                      Clk_CI,
    input  logic                      Reset_RBI,
    input  logic [NUM_REQ*HV_DIM-1:0] QueryIn_DI,
    input  logic [NUM_REQ-1:0]        ValidIn_SI,
    output logic [NUM_REQ-1:0]        ReadyOut_SO,
    output logic [NUM_REQ-1:0]        ValidOut_SO,
    input  logic [NUM_REQ-1:0]        ReadyIn_SI,
    output logic [LABEL_W-1:0]        LabelOut_A_DO,
    output logic [LABEL_W-1:0]        LabelOut_V_DO,
    output logic [DIST_W-1:0]         DistanceOut_A_DO,
    output logic [DIST_W-1:0]         DistanceOut_V_DO,
    output logic                      ErrorOut_SO,
    output logic [HV_DIM-1:0]         AmHv_DO,
    output logic                      AmValid_SO,
    input  logic                      AmReady_SI,
    input  logic                      AmValid_SI,
    output logic                      AmReady_SO,
    input  logic [LABEL_W-1:0]        AmLabel_A_DI,
    input  logic [LABEL_W-1:0]        AmLabel_V_DI,
    input  logic [DIST_W-1:0]         AmDist_A_DI,
    input  logic [DIST_W-1:0]         AmDist_V_DI
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam bit TO_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_REQ - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    logic [1:0]         state_q;
    logic [PTR_W-1:0]   rr_q;
    logic [PTR_W-1:0]   owner_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [HV_DIM-1:0]  query_q;
    logic [LABEL_W-1:0] label_a_q;
    logic [LABEL_W-1:0] label_v_q;
    logic [DIST_W-1:0]  dist_a_q;
    logic [DIST_W-1:0]  dist_v_q;
    logic               err_q;

    logic               grant_found;
    logic [PTR_W-1:0]   grant_idx;
    logic [PTR_W-1:0]   rr_next;
    logic [HV_DIM-1:0]  sel_query;
    logic               timeout_hit;

    // Search starts at the rr pointer so the last winner has lowest priority.
    always_comb begin
        int unsigned cand;
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = (32'(rr_q) + 32'(i)) % 32'(NUM_REQ);
            if (!grant_found && ValidIn_SI[PTR_W'(cand)]) begin
                grant_found = 1'b1;
                grant_idx   = PTR_W'(cand);
            end
        end
    end

    always_comb begin
        if (grant_idx == PTR_LAST) begin
            rr_next = '0;
        end else begin
            rr_next = grant_idx + PTR_W'(1);
        end
    end

    always_comb begin
        sel_query = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == PTR_W'(i)) begin
                sel_query = QueryIn_DI[i*HV_DIM +: HV_DIM];
            end
        end
    end

    assign timeout_hit = TO_EN && (cnt_q == CNT_LAST);

    always_ff @(posedge Clk_CI or negedge Reset_RBI) begin
        if (!Reset_RBI) begin
            state_q   <= S_IDLE;
            rr_q      <= '0;
            owner_q   <= '0;
            cnt_q     <= '0;
            query_q   <= '0;
            label_a_q <= '0;
            label_v_q <= '0;
            dist_a_q  <= '0;
            dist_v_q  <= '0;
            err_q     <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (grant_found) begin
                        query_q <= sel_query;
                        owner_q <= grant_idx;
                        rr_q    <= rr_next;
                        cnt_q   <= '0;
                        state_q <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (timeout_hit) begin
                        label_a_q <= '0;
                        label_v_q <= '0;
                        dist_a_q  <= '1;
                        dist_v_q  <= '1;
                        err_q     <= 1'b1;
                        state_q   <= S_RESP;
                    end else if (AmReady_SI) begin
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    // A real answer beats a simultaneous expiry.
                    if (AmValid_SI) begin
                        label_a_q <= AmLabel_A_DI;
                        label_v_q <= AmLabel_V_DI;
                        dist_a_q  <= AmDist_A_DI;
                        dist_v_q  <= AmDist_V_DI;
                        err_q     <= 1'b0;
                        state_q   <= S_RESP;
                    end else if (timeout_hit) begin
                        label_a_q <= '0;
                        label_v_q <= '0;
                        dist_a_q  <= '1;
                        dist_v_q  <= '1;
                        err_q     <= 1'b1;
                        state_q   <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (ReadyIn_SI[owner_q]) begin
                        err_q   <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        ReadyOut_SO = '0;
        if (state_q == S_IDLE) begin
            ReadyOut_SO[grant_idx] = grant_found;
        end
    end

    always_comb begin
        ValidOut_SO = '0;
        if (state_q == S_RESP) begin
            ValidOut_SO[owner_q] = 1'b1;
        end
    end

    // Stale AM results are accepted and dropped everywhere except RESP.
    assign AmValid_SO       = (state_q == S_ISSUE);
    assign AmReady_SO       = (state_q != S_RESP);
    assign AmHv_DO          = query_q;
    assign LabelOut_A_DO    = label_a_q;
    assign LabelOut_V_DO    = label_v_q;
    assign DistanceOut_A_DO = dist_a_q;
    assign DistanceOut_V_DO = dist_v_q;
    assign ErrorOut_SO      = err_q;

endmodule

// File: tb/tb_am_query_scheduler.sv
// Directed bench for am_query_scheduler: arbitration, handshakes,
// backpressure, timeout, async reset and expiry/answer race.
module tb_am_query_scheduler;

    localparam int NUM_REQ = 2;
    localparam int HV_DIM  = 2000;
    localparam int LABEL_W = 1;
    localparam int DIST_W  = 11;
    localparam int TIMEOUT = 8;

    logic                      clk = 1'b0;
    logic                      rst_n = 1'b0;
    logic [NUM_REQ*HV_DIM-1:0] query_in;
    logic [NUM_REQ-1:0]        valid_in;
    logic [NUM_REQ-1:0]        ready_out;
    logic [NUM_REQ-1:0]        valid_out;
    logic [NUM_REQ-1:0]        ready_in;
    logic [LABEL_W-1:0]        label_a;
    logic [LABEL_W-1:0]        label_v;
    logic [DIST_W-1:0]         dist_a;
    logic [DIST_W-1:0]         dist_v;
    logic                      error_out;
    logic [HV_DIM-1:0]         am_hv;
    logic                      am_valid_o;
    logic                      am_ready_i;
    logic                      am_valid_i;
    logic                      am_ready_o;
    logic [LABEL_W-1:0]        am_label_a;
    logic [LABEL_W-1:0]        am_label_v;
    logic [DIST_W-1:0]         am_dist_a;
    logic [DIST_W-1:0]         am_dist_v;

    logic [HV_DIM-1:0] q0;
    logic [HV_DIM-1:0] q1;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    am_query_scheduler #(
        .NUM_REQ       (NUM_REQ),
        .HV_DIM        (HV_DIM),
        .LABEL_W       (LABEL_W),
        .DIST_W        (DIST_W),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .Clk_CI          (clk),
        .Reset_RBI       (rst_n),
        .QueryIn_DI      (query_in),
        .ValidIn_SI      (valid_in),
        .ReadyOut_SO     (ready_out),
        .ValidOut_SO     (valid_out),
        .ReadyIn_SI      (ready_in),
        .LabelOut_A_DO   (label_a),
        .LabelOut_V_DO   (label_v),
        .DistanceOut_A_DO(dist_a),
        .DistanceOut_V_DO(dist_v),
        .ErrorOut_SO     (error_out),
        .AmHv_DO         (am_hv),
        .AmValid_SO      (am_valid_o),
        .AmReady_SI      (am_ready_i),
        .AmValid_SI      (am_valid_i),
        .AmReady_SO      (am_ready_o),
        .AmLabel_A_DI    (am_label_a),
        .AmLabel_V_DI    (am_label_v),
        .AmDist_A_DI     (am_dist_a),
        .AmDist_V_DI     (am_dist_v)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    task automatic idle_inputs;
        valid_in   = '0;
        ready_in   = '0;
        am_ready_i = 1'b0;
        am_valid_i = 1'b0;
        am_label_a = '0;
        am_label_v = '0;
        am_dist_a  = '0;
        am_dist_v  = '0;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        idle_inputs();
        tick();
        tick();
        rst_n = 1'b1;
        settle();
    endtask

    // AM accepts in ISSUE, answers one cycle later; leaves DUT in RESP.
    task automatic am_respond(input logic la, input logic lv,
                              input logic [DIST_W-1:0] da,
                              input logic [DIST_W-1:0] dv);
        am_ready_i = 1'b1;
        tick();
        am_ready_i = 1'b0;
        am_valid_i = 1'b1;
        am_label_a = la;
        am_label_v = lv;
        am_dist_a  = da;
        am_dist_v  = dv;
        tick();
        am_valid_i = 1'b0;
        settle();
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        idle_inputs();
        tick();
        checks++;
        if (ready_out !== 2'b00 || valid_out !== 2'b00) begin
            failures++;
            $display("FAIL reset_rv ready=%b valid=%b exp 00 00", ready_out, valid_out);
        end
        checks++;
        if (am_valid_o !== 1'b0 || error_out !== 1'b0 || am_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL reset_am amv=%b err=%b amr=%b exp 0 0 1",
                     am_valid_o, error_out, am_ready_o);
        end
        checks++;
        if (am_hv !== '0 || dist_a !== '0 || dist_v !== '0 ||
            label_a !== '0 || label_v !== '0) begin
            failures++;
            $display("FAIL reset_regs hv=%h da=%h dv=%h exp 0", am_hv[31:0], dist_a, dist_v);
        end
        rst_n = 1'b1;
        settle();
    endtask

    task automatic test_single_query;
        valid_in = 2'b01;
        settle();
        checks++;
        if (ready_out !== 2'b01) begin
            failures++;
            $display("FAIL single_grant ready=%b exp 01", ready_out);
        end
        tick();
        valid_in = 2'b00;
        settle();
        checks++;
        if (ready_out !== 2'b00 || am_valid_o !== 1'b1 || am_hv !== q0) begin
            failures++;
            $display("FAIL single_issue ready=%b amv=%b hv=%h exp 00 1 %h",
                     ready_out, am_valid_o, am_hv[31:0], q0[31:0]);
        end
        am_respond(1'b1, 1'b0, 11'd400, 11'd650);
        checks++;
        if (valid_out !== 2'b01 || error_out !== 1'b0 || am_ready_o !== 1'b0) begin
            failures++;
            $display("FAIL single_resp valid=%b err=%b amr=%b exp 01 0 0",
                     valid_out, error_out, am_ready_o);
        end
        checks++;
        if (label_a !== 1'b1 || label_v !== 1'b0 ||
            dist_a !== 11'd400 || dist_v !== 11'd650) begin
            failures++;
            $display("FAIL single_data la=%b lv=%b da=%0d dv=%0d exp 1 0 400 650",
                     label_a, label_v, dist_a, dist_v);
        end
        checks++;
        if (ready_out !== 2'b00) begin
            failures++;
            $display("FAIL single_one_pulse ready=%b exp 00", ready_out);
        end
        ready_in = 2'b01;
        tick();
        ready_in = 2'b00;
        settle();
        checks++;
        if (valid_out !== 2'b00 || ready_out !== 2'b00) begin
            failures++;
            $display("FAIL single_done valid=%b ready=%b exp 00 00", valid_out, ready_out);
        end
    endtask

    task automatic test_round_robin;
        logic [1:0] exp_oh;
        do_reset();
        valid_in = 2'b11;
        for (int k = 0; k < 6; k++) begin
            exp_oh = (k % 2 == 0) ? 2'b01 : 2'b10;
            settle();
            checks++;
            if (ready_out !== exp_oh) begin
                failures++;
                $display("FAIL rr_grant k=%0d ready=%b exp %b", k, ready_out, exp_oh);
            end
            tick();
            checks++;
            if (ready_out !== 2'b00 ||
                am_hv !== ((k % 2 == 0) ? q0 : q1)) begin
                failures++;
                $display("FAIL rr_issue k=%0d ready=%b hv=%h", k, ready_out, am_hv[31:0]);
            end
            am_respond(1'(k & 1), 1'(~k & 1), 11'(100 + k), 11'(200 + k));
            checks++;
            if (valid_out !== exp_oh || dist_a !== 11'(100 + k) ||
                dist_v !== 11'(200 + k) || label_a !== 1'(k & 1)) begin
                failures++;
                $display("FAIL rr_resp k=%0d valid=%b da=%0d dv=%0d exp %b %0d %0d",
                         k, valid_out, dist_a, dist_v, exp_oh, 100 + k, 200 + k);
            end
            ready_in = 2'b11;
            tick();
            ready_in = 2'b00;
        end
        valid_in = 2'b00;
        settle();
    endtask

    task automatic test_backpressure;
        valid_in = 2'b10;
        settle();
        checks++;
        if (ready_out !== 2'b10) begin
            failures++;
            $display("FAIL bp_grant ready=%b exp 10", ready_out);
        end
        tick();
        valid_in = 2'b11;
        am_respond(1'b0, 1'b1, 11'd777, 11'd123);
        for (int i = 0; i < 20; i++) begin
            checks++;
            if (valid_out !== 2'b10 || dist_a !== 11'd777 || dist_v !== 11'd123 ||
                label_v !== 1'b1 || ready_out !== 2'b00 || am_valid_o !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold i=%0d valid=%b da=%0d dv=%0d ready=%b amv=%b",
                         i, valid_out, dist_a, dist_v, ready_out, am_valid_o);
            end
            tick();
        end
        ready_in = 2'b10;
        tick();
        ready_in = 2'b00;
        valid_in = 2'b00;
        settle();
        checks++;
        if (valid_out !== 2'b00) begin
            failures++;
            $display("FAIL bp_release valid=%b exp 00", valid_out);
        end
    endtask

    task automatic test_timeout;
        valid_in = 2'b01;
        settle();
        checks++;
        if (ready_out !== 2'b01) begin
            failures++;
            $display("FAIL to_grant ready=%b exp 01", ready_out);
        end
        tick();
        valid_in = 2'b00;
        am_ready_i = 1'b1;
        tick();
        am_ready_i = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
        end
        checks++;
        if (valid_out !== 2'b00 || am_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL to_early valid=%b amr=%b exp 00 1", valid_out, am_ready_o);
        end
        tick();
        checks++;
        if (valid_out !== 2'b01 || error_out !== 1'b1) begin
            failures++;
            $display("FAIL to_expire valid=%b err=%b exp 01 1", valid_out, error_out);
        end
        checks++;
        if (label_a !== 1'b0 || label_v !== 1'b0 ||
            dist_a !== 11'h7FF || dist_v !== 11'h7FF) begin
            failures++;
            $display("FAIL to_data la=%b lv=%b da=%h dv=%h exp 0 0 7ff 7ff",
                     label_a, label_v, dist_a, dist_v);
        end
        am_valid_i = 1'b1;
        am_label_a = 1'b1;
        am_label_v = 1'b1;
        am_dist_a  = 11'd5;
        am_dist_v  = 11'd5;
        settle();
        checks++;
        if (am_ready_o !== 1'b0) begin
            failures++;
            $display("FAIL to_resp_amready amr=%b exp 0", am_ready_o);
        end
        tick();
        checks++;
        if (error_out !== 1'b1 || dist_a !== 11'h7FF || label_a !== 1'b0) begin
            failures++;
            $display("FAIL to_late_ignored err=%b da=%h la=%b exp 1 7ff 0",
                     error_out, dist_a, label_a);
        end
        ready_in = 2'b01;
        tick();
        ready_in = 2'b00;
        tick();
        am_valid_i = 1'b0;
        tick();
        checks++;
        if (valid_out !== 2'b00 || error_out !== 1'b0 || am_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL to_drain valid=%b err=%b amv=%b exp 00 0 0",
                     valid_out, error_out, am_valid_o);
        end
    endtask

    task automatic test_reset_in_wait;
        valid_in = 2'b01;
        tick();
        valid_in = 2'b00;
        am_ready_i = 1'b1;
        tick();
        am_ready_i = 1'b0;
        rst_n = 1'b0;
        settle();
        checks++;
        if (valid_out !== 2'b00 || am_valid_o !== 1'b0 || error_out !== 1'b0 ||
            ready_out !== 2'b00 || am_ready_o !== 1'b1 || am_hv !== '0) begin
            failures++;
            $display("FAIL rst_async valid=%b amv=%b err=%b ready=%b amr=%b hv=%h",
                     valid_out, am_valid_o, error_out, ready_out, am_ready_o, am_hv[31:0]);
        end
        rst_n = 1'b1;
        am_valid_i = 1'b1;
        am_label_a = 1'b1;
        am_dist_a  = 11'd999;
        tick();
        am_valid_i = 1'b0;
        settle();
        checks++;
        if (valid_out !== 2'b00) begin
            failures++;
            $display("FAIL rst_stale valid=%b exp 00", valid_out);
        end
        valid_in = 2'b10;
        settle();
        checks++;
        if (ready_out !== 2'b10) begin
            failures++;
            $display("FAIL rst_regrant ready=%b exp 10", ready_out);
        end
        tick();
        valid_in = 2'b00;
        settle();
        checks++;
        if (am_hv !== q1 || am_valid_o !== 1'b1) begin
            failures++;
            $display("FAIL rst_issue hv=%h amv=%b exp %h 1", am_hv[31:0], am_valid_o, q1[31:0]);
        end
        am_respond(1'b1, 1'b1, 11'd55, 11'd66);
        checks++;
        if (valid_out !== 2'b10 || dist_a !== 11'd55 || dist_v !== 11'd66 ||
            error_out !== 1'b0) begin
            failures++;
            $display("FAIL rst_result valid=%b da=%0d dv=%0d err=%b exp 10 55 66 0",
                     valid_out, dist_a, dist_v, error_out);
        end
        ready_in = 2'b10;
        tick();
        ready_in = 2'b00;
        settle();
    endtask

    task automatic test_simultaneous;
        valid_in = 2'b01;
        tick();
        valid_in = 2'b00;
        am_ready_i = 1'b1;
        tick();
        am_ready_i = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
        end
        checks++;
        if (valid_out !== 2'b00) begin
            failures++;
            $display("FAIL race_early valid=%b exp 00", valid_out);
        end
        am_valid_i = 1'b1;
        am_label_a = 1'b0;
        am_label_v = 1'b1;
        am_dist_a  = 11'd3;
        am_dist_v  = 11'd1000;
        tick();
        am_valid_i = 1'b0;
        settle();
        checks++;
        if (valid_out !== 2'b01 || error_out !== 1'b0 || dist_a !== 11'd3 ||
            dist_v !== 11'd1000 || label_v !== 1'b1 || label_a !== 1'b0) begin
            failures++;
            $display("FAIL race_result valid=%b err=%b da=%0d dv=%0d lv=%b exp 01 0 3 1000 1",
                     valid_out, error_out, dist_a, dist_v, label_v);
        end
        ready_in = 2'b01;
        tick();
        ready_in = 2'b00;
        settle();
    endtask

    initial begin
        q0 = {125{16'hA5C3}};
        q1 = {125{16'h3C5A}};
        query_in = {q1, q0};
        idle_inputs();
        test_reset();
        test_single_query();
        test_round_robin();
        test_backpressure();
        test_timeout();
        test_reset_in_wait();
        test_simultaneous();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
